// File: rtl/hamming_secded_decoder.sv
// Registered SECDED decoder for the extended Hamming (16,11) code, one word per cycle.
// Optional saturating error counters are built when HAMMING_ERR_CNT_EN is defined.
module hamming_secded_decoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [15:0]      in_code,
    output logic             out_valid,
    output logic [10:0]      out_data,
    output logic [15:0]      out_code,
    output logic [3:0]       out_syndrome,
    output logic             out_single_err,
    output logic             out_double_err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] single_cnt,
    output logic [CNT_W-1:0] double_cnt
);

    logic [3:0]  syndrome;
    logic        parity;
    logic [15:0] corr_code;
    logic        single_err;
    logic        double_err;

    logic        valid_q, valid_d;
    logic [10:0] data_q, data_d;
    logic [15:0] code_q, code_d;
    logic [3:0]  syn_q, syn_d;
    logic        single_q, single_d;
    logic        double_q, double_d;

    always_comb begin
        syndrome = 4'd0;
        for (int i = 1; i < 16; i++) begin
            if (in_code[i]) begin
                syndrome = syndrome ^ 4'(i);
            end
        end
        parity = ^in_code;
    end

    // A zero syndrome with odd parity means the overall parity bit itself flipped.
    always_comb begin
        corr_code  = in_code;
        single_err = parity;
        double_err = !parity && (syndrome != 4'd0);
        if (parity) begin
            corr_code[syndrome] = ~in_code[syndrome];
        end
    end

    always_comb begin
        valid_d  = in_valid;
        data_d   = data_q;
        code_d   = code_q;
        syn_d    = syn_q;
        single_d = single_q;
        double_d = double_q;
        if (in_valid) begin
            data_d   = {corr_code[15:9], corr_code[7:5], corr_code[3]};
            code_d   = corr_code;
            syn_d    = syndrome;
            single_d = single_err;
            double_d = double_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            code_q   <= '0;
            syn_q    <= '0;
            single_q <= 1'b0;
            double_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            code_q   <= code_d;
            syn_q    <= syn_d;
            single_q <= single_d;
            double_q <= double_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_data       = data_q;
    assign out_code       = code_q;
    assign out_syndrome   = syn_q;
    assign out_single_err = single_q;
    assign out_double_err = double_q;

`ifdef HAMMING_ERR_CNT_EN
    logic [CNT_W-1:0] single_cnt_q, single_cnt_d;
    logic [CNT_W-1:0] double_cnt_q, double_cnt_d;

    always_comb begin
        single_cnt_d = single_cnt_q;
        double_cnt_d = double_cnt_q;
        if (cnt_clr) begin
            single_cnt_d = '0;
            double_cnt_d = '0;
        end else if (in_valid) begin
            if (single_err && (single_cnt_q != '1)) begin
                single_cnt_d = single_cnt_q + 1'b1;
            end
            if (double_err && (double_cnt_q != '1)) begin
                double_cnt_d = double_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            single_cnt_q <= '0;
            double_cnt_q <= '0;
        end else begin
            single_cnt_q <= single_cnt_d;
            double_cnt_q <= double_cnt_d;
        end
    end

    assign single_cnt = single_cnt_q;
    assign double_cnt = double_cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign single_cnt     = '0;
    assign double_cnt     = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Randomized self-checking bench for hamming_secded_decoder against an encode/inject model.
// Counter expectations follow HAMMING_ERR_CNT_EN; a CNT_W=2 copy exercises saturation.
module tb_hamming_secded_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_code = '0;
    logic        cnt_clr = 1'b0;

    logic        out_valid;
    logic [10:0] out_data;
    logic [15:0] out_code;
    logic [3:0]  out_syndrome;
    logic        out_single_err;
    logic        out_double_err;
    logic [15:0] single_cnt;
    logic [15:0] double_cnt;

    logic        s_valid;
    logic [10:0] s_data;
    logic [15:0] s_code;
    logic [3:0]  s_syn;
    logic        s_se;
    logic        s_de;
    logic [1:0]  s_scnt;
    logic [1:0]  s_dcnt;

    int checks = 0;
    int failures = 0;

    // Behavioural model state: last registered outputs and unbounded error tallies.
    logic        m_valid;
    logic [10:0] m_data;
    logic [15:0] m_code;
    logic [3:0]  m_syn;
    logic        m_se;
    logic        m_de;
    int          m_scnt;
    int          m_dcnt;

    always #5 clk = ~clk;

    hamming_secded_decoder #(.CNT_W(16)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_code        (in_code),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_code       (out_code),
        .out_syndrome   (out_syndrome),
        .out_single_err (out_single_err),
        .out_double_err (out_double_err),
        .cnt_clr        (cnt_clr),
        .single_cnt     (single_cnt),
        .double_cnt     (double_cnt)
    );

    hamming_secded_decoder #(.CNT_W(2)) u_dut_small (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_code        (in_code),
        .out_valid      (s_valid),
        .out_data       (s_data),
        .out_code       (s_code),
        .out_syndrome   (s_syn),
        .out_single_err (s_se),
        .out_double_err (s_de),
        .cnt_clr        (cnt_clr),
        .single_cnt     (s_scnt),
        .double_cnt     (s_dcnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int data_pos(input int k);
        int p;
        int n;
        n = 0;
        data_pos = 0;
        for (p = 1; p < 16; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == k) data_pos = p;
                n++;
            end
        end
    endfunction

    function automatic logic [15:0] encode(input logic [10:0] msg);
        logic [15:0] cw;
        cw = '0;
        for (int k = 0; k < 11; k++) cw[data_pos(k)] = msg[k];
        for (int p = 1; p < 16; p = p * 2) begin
            for (int i = 1; i < 16; i++) begin
                if ((i & p) != 0 && i != p) cw[p] = cw[p] ^ cw[i];
            end
        end
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    function automatic logic [10:0] extract(input logic [15:0] cw);
        logic [10:0] m;
        for (int k = 0; k < 11; k++) m[k] = cw[data_pos(k)];
        return m;
    endfunction

    function automatic logic [31:0] sat(input int v, input int maxv);
        return (v > maxv) ? 32'(maxv) : 32'(v);
    endfunction

    // cls: 0 = clean, 1 = single error, 2 = double error.
    task automatic drive(input logic v, input logic [15:0] code, input logic clr,
                         input logic [10:0] ed, input logic [15:0] ec, input logic [3:0] es,
                         input int cls);
        in_valid = v;
        in_code  = code;
        cnt_clr  = clr;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_valid = 1'b0; m_data = '0; m_code = '0; m_syn = '0;
            m_se = 1'b0; m_de = 1'b0; m_scnt = 0; m_dcnt = 0;
        end else begin
            m_valid = v;
            if (v) begin
                m_data = ed; m_code = ec; m_syn = es;
                m_se = (cls == 1); m_de = (cls == 2);
            end
            if (clr) begin
                m_scnt = 0;
                m_dcnt = 0;
            end else if (v) begin
                if (cls == 1) m_scnt++;
                if (cls == 2) m_dcnt++;
            end
        end
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_code", 32'(out_code), 32'(m_code));
        check("out_syndrome", 32'(out_syndrome), 32'(m_syn));
        check("out_single_err", 32'(out_single_err), 32'(m_se));
        check("out_double_err", 32'(out_double_err), 32'(m_de));
`ifdef HAMMING_ERR_CNT_EN
        check("single_cnt", 32'(single_cnt), sat(m_scnt, 65535));
        check("double_cnt", 32'(double_cnt), sat(m_dcnt, 65535));
        check("single_cnt_w2", 32'(s_scnt), sat(m_scnt, 3));
        check("double_cnt_w2", 32'(s_dcnt), sat(m_dcnt, 3));
`else
        check("single_cnt", 32'(single_cnt), 32'd0);
        check("double_cnt", 32'(double_cnt), 32'd0);
        check("single_cnt_w2", 32'(s_scnt), 32'd0);
        check("double_cnt_w2", 32'(s_dcnt), 32'd0);
`endif
    endtask

    initial begin
        logic [10:0] msg;
        logic [15:0] cw;
        logic [15:0] bad;
        logic [3:0]  syn;
        int          nf;
        int          p0;
        int          p1;

        m_valid = 1'b0; m_data = '0; m_code = '0; m_syn = '0;
        m_se = 1'b0; m_de = 1'b0; m_scnt = 0; m_dcnt = 0;

        // Word presented during reset must be discarded.
        rst_n = 1'b0;
        drive(1'b1, 16'h0018, 1'b0, 11'h0, 16'h0, 4'h0, 0);
        drive(1'b1, 16'hFFBF, 1'b0, 11'h0, 16'h0, 4'h0, 0);
        rst_n = 1'b1;

        drive(1'b1, 16'hFFFF, 1'b0, 11'h7FF, 16'hFFFF, 4'd0, 0);
        drive(1'b1, 16'hFFBF, 1'b0, 11'h7FF, 16'hFFFF, 4'd6, 1);
        drive(1'b1, 16'h0001, 1'b0, 11'h000, 16'h0000, 4'd0, 1);
        drive(1'b1, 16'h0008, 1'b0, 11'h000, 16'h0000, 4'd3, 1);
        drive(1'b1, 16'h0018, 1'b0, 11'h001, 16'h0018, 4'd7, 2);
        // Idle cycles: outputs hold, out_valid drops.
        drive(1'b0, 16'h1234, 1'b0, 11'h0, 16'h0, 4'h0, 0);
        drive(1'b0, 16'hFFBF, 1'b0, 11'h0, 16'h0, 4'h0, 0);
        // Clear coincident with a single error: that error is not counted.
        drive(1'b1, 16'hFFBF, 1'b1, 11'h7FF, 16'hFFFF, 4'd6, 1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'h0001, 1'b0, 11'h000, 16'h0000, 4'd0, 1);
        end
        drive(1'b1, 16'h0018, 1'b0, 11'h001, 16'h0018, 4'd7, 2);

        for (int it = 0; it < 400; it++) begin
            msg = 11'($urandom);
            cw  = encode(msg);
            nf  = int'($urandom_range(0, 2));
            p0  = int'($urandom_range(0, 15));
            p1  = (p0 + int'($urandom_range(1, 15))) % 16;
            bad = cw;
            syn = 4'd0;
            if (nf >= 1) begin
                bad[p0] = ~bad[p0];
                syn = syn ^ 4'(p0);
            end
            if (nf == 2) begin
                bad[p1] = ~bad[p1];
                syn = syn ^ 4'(p1);
            end
            if (nf < 2) begin
                drive(($urandom_range(0, 4) != 0), bad, ($urandom_range(0, 31) == 0),
                      msg, cw, syn, nf);
            end else begin
                drive(($urandom_range(0, 4) != 0), bad, ($urandom_range(0, 31) == 0),
                      extract(bad), bad, syn, nf);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
